// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline with a memory-wait FSM and watchdog.
// Optional stall performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_unit_mc #(
    parameter int RA_W        = 5,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  rsd,
    input  logic [RA_W-1:0]  rtd,
    input  logic [RA_W-1:0]  rse,
    input  logic [RA_W-1:0]  rte,
    input  logic [RA_W-1:0]  writerege,
    input  logic [RA_W-1:0]  writeregm,
    input  logic [RA_W-1:0]  writeregw,
    input  logic             regwritee,
    input  logic             regwritem,
    input  logic             regwritew,
    input  logic             memtorege,
    input  logic             memtoregm,
    input  logic             branchd,
    input  logic             memreqm,
    input  logic             memready,
    output logic             stallf,
    output logic             stalld,
    output logic             stalle,
    output logic             stallm,
    output logic             stallw,
    output logic             flushe,
    output logic             forwardad,
    output logic             forwardbd,
    output logic [1:0]       forwardae,
    output logic [1:0]       forwardbe,
    output logic             mem_busy,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] perf_lw,
    output logic [CNT_W-1:0] perf_br,
    output logic [CNT_W-1:0] perf_mem
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] wd_cnt;
    logic [TO_W-1:0] wd_cnt_next;
    logic            memstall;
    logic            timeout_hit;
    logic            lwstall;
    logic            brstall;

    // Register 0 is hard-wired, so a match on it never forwards or stalls.
    function automatic logic reg_match(input logic [RA_W-1:0] src,
                                       input logic [RA_W-1:0] dst,
                                       input logic            en);
        return en && (src != '0) && (src == dst);
    endfunction

    always_comb begin
        lwstall = reg_match(rsd, rte, memtorege) || reg_match(rtd, rte, memtorege);
        brstall = branchd && (reg_match(rsd, writerege, regwritee) ||
                              reg_match(rtd, writerege, regwritee) ||
                              reg_match(rsd, writeregm, memtoregm) ||
                              reg_match(rtd, writeregm, memtoregm));
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_next  = state;
        wd_cnt_next = wd_cnt;
        memstall    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (memreqm && !memready) begin
                    memstall   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memready) begin
                    state_next  = S_IDLE;
                    wd_cnt_next = '0;
                end else if (wd_cnt >= TIMEOUT_LIM) begin
                    // Forced release: let the pipeline move on and flag the hang.
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                    wd_cnt_next = '0;
                end else begin
                    memstall    = 1'b1;
                    wd_cnt_next = wd_cnt + TO_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state  <= state_next;
            wd_cnt <= wd_cnt_next;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign mem_busy = (state == S_WAIT);

    always_comb begin
        stallf    = 1'b0;
        stalld    = 1'b0;
        stalle    = 1'b0;
        stallm    = 1'b0;
        stallw    = 1'b0;
        flushe    = 1'b0;
        forwardad = 1'b0;
        forwardbd = 1'b0;
        forwardae = 2'b00;
        forwardbe = 2'b00;
        if (!reset) begin
            stallf    = lwstall | brstall | memstall;
            stalld    = lwstall | brstall | memstall;
            stalle    = memstall;
            stallm    = memstall;
            stallw    = memstall;
            // A frozen E stage keeps its instruction; bubbling it would lose it.
            flushe    = (lwstall | brstall) & !memstall;
            forwardad = reg_match(rsd, writeregm, regwritem);
            forwardbd = reg_match(rtd, writeregm, regwritem);
            if (reg_match(rse, writeregm, regwritem)) begin
                forwardae = 2'b10;
            end else if (reg_match(rse, writeregw, regwritew)) begin
                forwardae = 2'b01;
            end
            if (reg_match(rte, writeregm, regwritem)) begin
                forwardbe = 2'b10;
            end else if (reg_match(rte, writeregw, regwritew)) begin
                forwardbe = 2'b01;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] lw_q;
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mem_q;

    // Saturating counters: each sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            lw_q  <= '0;
            br_q  <= '0;
            mem_q <= '0;
        end else begin
            if (lwstall && !memstall && (lw_q != '1)) begin
                lw_q <= lw_q + CNT_W'(1);
            end
            if (brstall && !memstall && !lwstall && (br_q != '1)) begin
                br_q <= br_q + CNT_W'(1);
            end
            if (memstall && (mem_q != '1)) begin
                mem_q <= mem_q + CNT_W'(1);
            end
        end
    end

    assign perf_lw  = lw_q;
    assign perf_br  = br_q;
    assign perf_mem = mem_q;
`else
    assign perf_lw  = '0;
    assign perf_br  = '0;
    assign perf_mem = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed test-plan scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_unit_mc;

    localparam int RA_W        = 5;
    localparam int TO_W        = 8;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 2;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [RA_W-1:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
    logic regwritee, regwritem, regwritew, memtorege, memtoregm, branchd, memreqm, memready;
    logic stallf, stalld, stalle, stallm, stallw, flushe, forwardad, forwardbd;
    logic [1:0] forwardae, forwardbe;
    logic mem_busy, mem_timeout;
    logic [CNT_W-1:0] perf_lw, perf_br, perf_mem;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: is a memory access outstanding, how long has it waited, sticky flag, stall tallies.
    bit m_busy;
    int m_waited;
    bit m_to;
    int m_plw, m_pbr, m_pmem;

    hazard_unit_mc #(
        .RA_W(RA_W), .TO_W(TO_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rsd(rsd), .rtd(rtd), .rse(rse), .rte(rte),
        .writerege(writerege), .writeregm(writeregm), .writeregw(writeregw),
        .regwritee(regwritee), .regwritem(regwritem), .regwritew(regwritew),
        .memtorege(memtorege), .memtoregm(memtoregm), .branchd(branchd),
        .memreqm(memreqm), .memready(memready),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm), .stallw(stallw),
        .flushe(flushe), .forwardad(forwardad), .forwardbd(forwardbd),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .mem_busy(mem_busy), .mem_timeout(mem_timeout),
        .perf_lw(perf_lw), .perf_br(perf_br), .perf_mem(perf_mem)
    );

    always #5 clk = ~clk;

    function automatic bit same_nz(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] m_fwd_e(input logic [RA_W-1:0] src);
        if (regwritem && same_nz(src, writeregm)) return 2'b10;
        if (regwritew && same_nz(src, writeregw)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lw();
        return memtorege && (same_nz(rsd, rte) || same_nz(rtd, rte));
    endfunction

    function automatic bit m_br();
        bit dep_e, dep_m;
        dep_e = regwritee && (same_nz(rsd, writerege) || same_nz(rtd, writerege));
        dep_m = memtoregm && (same_nz(rsd, writeregm) || same_nz(rtd, writeregm));
        return branchd && (dep_e || dep_m);
    endfunction

    function automatic bit m_ms();
        if (!m_busy) return memreqm && !memready;
        return !memready && (m_waited < MEM_TIMEOUT);
    endfunction

    function automatic logic [13:0] exp_vec();
        bit ms, lw, br, hold;
        if (reset) return {12'b0, m_busy, m_to};
        ms = m_ms();
        lw = m_lw();
        br = m_br();
        hold = ms | lw | br;
        return {hold, hold, ms, ms, ms, (lw | br) & !ms,
                regwritem && same_nz(rsd, writeregm), regwritem && same_nz(rtd, writeregm),
                m_fwd_e(rse), m_fwd_e(rte), m_busy, m_to};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {stallf, stalld, stalle, stallm, stallw, flushe, forwardad, forwardbd,
                forwardae, forwardbe, mem_busy, mem_timeout};
    endfunction

    function automatic logic [3*CNT_W-1:0] exp_perf();
`ifdef HAZ_PERF_CNT_EN
        return {CNT_W'(m_plw), CNT_W'(m_pbr), CNT_W'(m_pmem)};
`else
        return '0;
`endif
    endfunction

    task automatic model_step();
        bit ms, lw, br;
        if (reset) begin
            m_busy = 0; m_waited = 0; m_to = 0;
            m_plw = 0; m_pbr = 0; m_pmem = 0;
            return;
        end
        ms = m_ms();
        lw = m_lw();
        br = m_br();
        if (lw && !ms && m_plw < CMAX) m_plw++;
        if (br && !ms && !lw && m_pbr < CMAX) m_pbr++;
        if (ms && m_pmem < CMAX) m_pmem++;
        if (m_busy) begin
            if (memready) begin
                m_busy = 0; m_waited = 0;
            end else if (m_waited >= MEM_TIMEOUT) begin
                m_busy = 0; m_waited = 0; m_to = 1;
            end else begin
                m_waited++;
            end
        end else if (memreqm && !memready) begin
            m_busy = 1; m_waited = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        {rsd, rtd, rse, rte, writerege, writeregm, writeregw} = '0;
        {regwritee, regwritem, regwritew, memtorege, memtoregm, branchd, memreqm, memready} = '0;
    endtask

    task automatic randomize_regs();
        rsd = RA_W'($urandom_range(0, 3)); rtd = RA_W'($urandom_range(0, 3));
        rse = RA_W'($urandom_range(0, 3)); rte = RA_W'($urandom_range(0, 3));
        writerege = RA_W'($urandom_range(0, 3));
        writeregm = RA_W'($urandom_range(0, 3));
        writeregw = RA_W'($urandom_range(0, 3));
        regwritee = 1'($urandom); regwritem = 1'($urandom); regwritew = 1'($urandom);
        memtorege = 1'($urandom); memtoregm = 1'($urandom); branchd = 1'($urandom);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            randomize_regs();
            memreqm = 1'b1;
            memready = 1'b0;
            #1;
            if (i >= 1) begin
                n_assert++;
                if (obs_vec() !== 14'b0 || perf_lw !== '0 || perf_br !== '0 || perf_mem !== '0) begin
                    n_fail++;
                    $display("FAIL reset[%0d]: got %b expected all zero", i, obs_vec());
                end
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        regwritem = 1; writeregm = 8; regwritew = 1; writeregw = 8; rse = 8;
        #1;
        n_assert++;
        if (forwardae !== 2'b10) begin
            n_fail++; $display("FAIL fwd_m_prio: got %b expected 10", forwardae);
        end
        tick();
        regwritem = 0;
        #1;
        n_assert++;
        if (forwardae !== 2'b01) begin
            n_fail++; $display("FAIL fwd_w: got %b expected 01", forwardae);
        end
        tick();
        regwritem = 1; writeregm = 0; rse = 0; writeregw = 0;
        #1;
        n_assert++;
        if (forwardae !== 2'b00) begin
            n_fail++; $display("FAIL fwd_r0: got %b expected 00", forwardae);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            randomize_regs();
            #1;
            n_assert++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL fwd_rand[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        memtorege = 1; rte = 9; rsd = 9;
        #1;
        n_assert++;
        if ({stallf, stalld, flushe, stalle} !== 4'b1110) begin
            n_fail++; $display("FAIL lw_stall: got %b expected 1110", {stallf, stalld, flushe, stalle});
        end
        tick();
        memtorege = 0;
        #1;
        n_assert++;
        if ({stallf, stalld, flushe, stalle} !== 4'b0000) begin
            n_fail++; $display("FAIL lw_release: got %b expected 0000", {stallf, stalld, flushe, stalle});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch();
        branchd = 1; rsd = 4; regwritee = 1; writerege = 4;
        #1;
        n_assert++;
        if ({stallf, stalld, flushe} !== 3'b111) begin
            n_fail++; $display("FAIL br_stall: got %b expected 111", {stallf, stalld, flushe});
        end
        tick();
        regwritee = 0; regwritem = 1; writeregm = 4;
        #1;
        n_assert++;
        if (forwardad !== 1'b1 || stallf !== 1'b0) begin
            n_fail++; $display("FAIL br_fwd: got ad=%b stallf=%b expected ad=1 stallf=0", forwardad, stallf);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        int stalls = 0;
        int flushes = 0;
        memreqm = 1;
        for (int i = 0; i < 4; i++) begin
            memready = (i == 3);
            #1;
            n_assert++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL memwait[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (i == 1 || i == 2) begin
                n_assert++;
                if (mem_busy !== 1'b1) begin
                    n_fail++; $display("FAIL memwait_busy[%0d]: got %b expected 1", i, mem_busy);
                end
            end
            if (stalle === 1'b1) stalls++;
            if (flushe === 1'b1) flushes++;
            tick();
        end
        memreqm = 0; memready = 0;
        #1;
        n_assert++;
        if (stalls != 3 || flushes != 0 || mem_busy !== 1'b0 || stallf !== 1'b0) begin
            n_fail++;
            $display("FAIL memwait_total: got stalls=%0d flushes=%0d busy=%b expected 3 0 0", stalls, flushes, mem_busy);
        end
        tick();
    endtask

    task automatic test_timeout();
        int stalls = 0;
        reset_pulse();
        clear_inputs();
        memreqm = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_assert++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (stalle === 1'b1) stalls++;
            tick();
        end
        memreqm = 0;
        #1;
        n_assert++;
        if (mem_timeout !== 1'b1 || mem_busy !== 1'b0 || stalls != 5) begin
            n_fail++;
            $display("FAIL timeout_flag: got to=%b busy=%b stalls=%0d expected 1 0 5", mem_timeout, mem_busy, stalls);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            randomize_regs();
            memreqm = 1'($urandom);
            memready = 1'b1;
            #1;
            n_assert++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_traffic[%0d]: got %b expected %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        n_assert++;
        if (mem_timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
        end
        clear_inputs();
        memreqm = 1;
        tick();
        tick();
        n_assert++;
        if (mem_busy !== 1'b1) begin
            n_fail++; $display("FAIL midwait_busy: got %b expected 1", mem_busy);
        end
        reset = 1'b1;
        tick();
        n_assert++;
        if (mem_busy !== 1'b0 || mem_timeout !== 1'b0) begin
            n_fail++; $display("FAIL midwait_reset: got busy=%b to=%b expected 0 0", mem_busy, mem_timeout);
        end
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        memtorege = 1; rte = 9; rsd = 9; memreqm = 1;
        for (int i = 0; i < 3; i++) begin
            memready = (i == 2);
            #1;
            n_assert++;
            if (i < 2 && {stallf, stalle, flushe} !== 3'b110) begin
                n_fail++; $display("FAIL b2b_wait[%0d]: got %b expected 110", i, {stallf, stalle, flushe});
            end else if (i == 2 && {stallf, stalle, flushe} !== 3'b101) begin
                n_fail++; $display("FAIL b2b_release: got %b expected 101", {stallf, stalle, flushe});
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] want;
`ifdef HAZ_PERF_CNT_EN
        want = 2'd3;
`else
        want = '0;
`endif
        reset_pulse();
        clear_inputs();
        memtorege = 1; rte = 9; rsd = 9;
        for (int i = 0; i < 5; i++) tick();
        memtorege = 0;
        #1;
        n_assert++;
        if (perf_lw !== want || perf_br !== '0 || perf_mem !== '0) begin
            n_fail++; $display("FAIL perf_lw_sat: got %0d expected %0d", perf_lw, want);
        end
        n_assert++;
        if ({perf_lw, perf_br, perf_mem} !== exp_perf()) begin
            n_fail++; $display("FAIL perf_model: got %h expected %h", {perf_lw, perf_br, perf_mem}, exp_perf());
        end
        tick();
    endtask

    task automatic test_random();
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            randomize_regs();
            memreqm  = ($urandom_range(0, 9) < 4);
            memready = ($urandom_range(0, 9) < 3);
            reset    = ($urandom_range(0, 99) == 0);
            #1;
            n_assert++;
            if (obs_vec() !== exp_vec() || {perf_lw, perf_br, perf_mem} !== exp_perf()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, obs_vec(),
                         {perf_lw, perf_br, perf_mem}, exp_vec(), exp_perf());
            end
            tick();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        m_busy = 0; m_waited = 0; m_to = 0;
        m_plw = 0; m_pbr = 0; m_pmem = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
